// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Grants are held for a whole packet (up to MAX_BURST bytes), each byte handshaken with tx_busy.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 grant_active,
    output logic [1:0]           grant_id,
    output logic                 err_ack_timeout
);

    localparam int unsigned     AckW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AckW-1:0] AckTimeout = AckW'(ACK_TIMEOUT);
    localparam logic [AckW-1:0] AckOne     = AckW'(1);
    localparam logic [4:0]      MaxBurst   = 5'(MAX_BURST);
    localparam logic [1:0]      LastReq    = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitAck,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [4:0]      byte_cnt_q, byte_cnt_d;
    logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
    logic            last_seen_q, last_seen_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            err_q, err_d;

    logic [1:0]      pick;
    logic            pick_vld;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;

    // First valid requester strictly after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!pick_vld && req_valid[rr_ptr_q + 2'(i)]) begin
                pick     = rr_ptr_q + 2'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid = req_valid[grant_id_q];
        g_last  = req_last[grant_id_q];
        g_data  = req_data[8*grant_id_q +: 8];
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StSend && !tx_busy) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        last_seen_d = last_seen_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_vld && !tx_busy) begin
                    grant_id_d = pick;
                    byte_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (g_valid && !tx_busy) begin
                    tx_data_d   = g_data;
                    tx_start_d  = 1'b1;
                    last_seen_d = g_last;
                    ack_cnt_d   = '0;
                    byte_cnt_d  = (byte_cnt_q == MaxBurst) ? byte_cnt_q : byte_cnt_q + 5'd1;
                    state_d     = StWaitAck;
                end
            end
            StWaitAck: begin
                // The error pulse fires as the count reaches the limit; the grant drops one
                // cycle later so the pulse is seen while grant_id still names the culprit.
                if (ack_cnt_q == AckTimeout) begin
                    rr_ptr_d = grant_id_q;
                    state_d  = StIdle;
                end else if (tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    ack_cnt_d = ack_cnt_q + AckOne;
                    err_d     = (ack_cnt_d == AckTimeout);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (last_seen_q || byte_cnt_q == MaxBurst) begin
                        rr_ptr_d = grant_id_q;
                        state_d  = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_id_q  <= 2'd0;
            rr_ptr_q    <= LastReq;
            byte_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            last_seen_q <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            last_seen_q <= last_seen_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            err_q       <= err_d;
        end
    end

    assign tx_data         = tx_data_q;
    assign tx_start        = tx_start_q;
    assign grant_id        = grant_id_q;
    assign grant_active    = (state_q != StIdle);
    assign err_ack_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a simple transmitter busy model,
// and a log of every tx_start compared against hand-written grant/byte sequences.
module tb_uart_tx_arbiter;

    localparam int BusyLen = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        err_ack_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .MAX_BURST  (16),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .tx_busy        (tx_busy),
        .grant_active   (grant_active),
        .grant_id       (grant_id),
        .err_ack_timeout(err_ack_timeout)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cycle        = 0;
    int         busy_cnt     = 0;
    bit         tx_dead      = 1'b0;
    logic [3:0] prev_hs      = 4'b0;
    bit         prev_err     = 1'b0;

    logic [8:0] pq [4][$];      // per-port {last, data}
    logic [9:0] glog [$];       // {grant_id, tx_data} per tx_start
    logic [9:0] expq [$];
    int         start_cyc [$];
    int         err_cyc [$];
    logic       ga_after_err [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        logic [8:0] h;
        for (int p = 0; p < 4; p++) begin
            if (pq[p].size() > 0) begin
                h = pq[p][0];
                req_valid[p]       = 1'b1;
                req_data[8*p +: 8] = h[7:0];
                req_last[p]        = h[8];
            end else begin
                req_valid[p]       = 1'b0;
                req_data[8*p +: 8] = 8'h00;
                req_last[p]        = 1'b0;
            end
        end
    endtask

    // One clock: busy model at negedge, then sample/log/drive 1 time unit later.
    task automatic step();
        @(negedge clk);
        cycle++;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start === 1'b1 && !tx_dead && !rst) begin
            tx_busy  = 1'b1;
            busy_cnt = BusyLen;
        end
        #1;
        chk("start_latency", {31'b0, tx_start}, {31'b0, prev_hs != 4'b0});
        chk("ready_while_busy", {28'b0, req_ready & {4{tx_busy}}}, 32'h0);
        if (prev_err) ga_after_err.push_back(grant_active);
        prev_err = err_ack_timeout;
        if (err_ack_timeout === 1'b1) err_cyc.push_back(cycle);
        if (tx_start === 1'b1) begin
            glog.push_back({grant_id, tx_data});
            start_cyc.push_back(cycle);
        end
        for (int p = 0; p < 4; p++) begin
            if (prev_hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        end
        drive_inputs();
        prev_hs = req_valid & req_ready;
    endtask

    function automatic bit all_idle();
        return pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
               pq[3].size() == 0 && grant_active === 1'b0 && !tx_busy;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!all_idle() && n < budget);
        chk({tag, "_done_in_budget"}, {31'b0, n < budget}, 32'h1);
    endtask

    task automatic check_log(input string tag, input int base);
        chk({tag, "_count"}, glog.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (base + i < glog.size()) chk($sformatf("%s[%0d]", tag, i), {22'b0, glog[base + i]},
                                            {22'b0, expq[i]});
        end
        expq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {28'b0, req_ready}, 32'h0);
        chk({tag, "_tx_start"}, {31'b0, tx_start}, 32'h0);
        chk({tag, "_tx_data"}, {24'b0, tx_data}, 32'h0);
        chk({tag, "_grant_id"}, {30'b0, grant_id}, 32'h0);
        chk({tag, "_grant_active"}, {31'b0, grant_active}, 32'h0);
        chk({tag, "_err"}, {31'b0, err_ack_timeout}, 32'h0);
    endtask

    initial begin
        int base;
        int sb;
        int eb;
        int gb;
        int n;

        rst       = 1'b1;
        tx_busy   = 1'b0;
        req_valid = 4'b0;
        req_data  = 32'h0;
        req_last  = 4'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // Two single-byte packets on ports 1 and 2.
        base = glog.size();
        pq[1].push_back({1'b1, 8'h11});
        pq[2].push_back({1'b1, 8'h22});
        drain("t1", 200);
        expq = '{{2'd1, 8'h11}, {2'd2, 8'h22}};
        check_log("t1_log", base);

        // Port 0 packet locks the grant while port 3 waits.
        base = glog.size();
        pq[0].push_back({1'b0, 8'hA1});
        pq[0].push_back({1'b0, 8'hA2});
        pq[0].push_back({1'b1, 8'hA3});
        step();
        pq[3].push_back({1'b1, 8'h33});
        drain("t2", 300);
        expq = '{{2'd0, 8'hA1}, {2'd0, 8'hA2}, {2'd0, 8'hA3}, {2'd3, 8'h33}};
        check_log("t2_log", base);

        // 20-byte stream on port 2: burst limit forces rotation to port 3 after 16.
        base = glog.size();
        for (int i = 0; i < 20; i++) pq[2].push_back({i == 19, 8'(8'h40 + i)});
        step();
        pq[3].push_back({1'b1, 8'h3C});
        drain("t3", 2000);
        for (int i = 0; i < 16; i++) expq.push_back({2'd2, 8'(8'h40 + i)});
        expq.push_back({2'd3, 8'h3C});
        for (int i = 16; i < 20; i++) expq.push_back({2'd2, 8'(8'h40 + i)});
        check_log("t3_log", base);

        // Reset while a 3-byte packet on port 2 is in WAIT_DONE.
        base = glog.size();
        pq[2].push_back({1'b0, 8'hC1});
        pq[2].push_back({1'b0, 8'hC2});
        pq[2].push_back({1'b1, 8'hC3});
        n = 0;
        while (glog.size() < base + 2 && n < 200) begin
            step();
            n++;
        end
        chk("t6_reach_second_byte", {31'b0, n < 200}, 32'h1);
        repeat (3) step();
        chk("t6_active_before_rst", {31'b0, grant_active}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        tx_busy  = 1'b0;
        busy_cnt = 0;
        for (int p = 0; p < 4; p++) pq[p].delete();
        drive_inputs();
        prev_hs = 4'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();
        chk("t6_no_start_after_rst", glog.size(), base + 2);
        pq[3].push_back({1'b1, 8'hD3});
        pq[1].push_back({1'b1, 8'hD1});
        drain("t6", 300);
        expq = '{{2'd2, 8'hC1}, {2'd2, 8'hC2}, {2'd1, 8'hD1}, {2'd3, 8'hD3}};
        check_log("t6_log", base);

        // All four ports continuously valid: strict rotation 0,1,2,3,0,1,2,3.
        base = glog.size();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) pq[p].push_back({1'b1, 8'(8'h80 + 16*p + k)});
        end
        drain("t5", 600);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) expq.push_back({2'(p), 8'(8'h80 + 16*p + k)});
        end
        check_log("t5_log", base);

        // Transmitter never acknowledges: each byte times out, next port still served.
        tx_dead = 1'b1;
        base = glog.size();
        sb   = start_cyc.size();
        eb   = err_cyc.size();
        gb   = ga_after_err.size();
        pq[0].push_back({1'b1, 8'hE0});
        pq[1].push_back({1'b1, 8'hE1});
        drain("t4", 200);
        expq = '{{2'd0, 8'hE0}, {2'd1, 8'hE1}};
        check_log("t4_log", base);
        chk("t4_err_count", err_cyc.size() - eb, 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (err_cyc.size() > eb + i && start_cyc.size() > sb + i)
                chk($sformatf("t4_err_delay[%0d]", i), err_cyc[eb + i] - start_cyc[sb + i], 32'd15);
            if (ga_after_err.size() > gb + i)
                chk($sformatf("t4_ga_after_err[%0d]", i), {31'b0, ga_after_err[gb + i]}, 32'h0);
        end
        tx_dead = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
